// File: rtl/temporizador_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and width.
package temporizador_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    ESGOTADO = 2'd3
  } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// Prescaler: counts 0..PRESC-1 while habilita is high, holds otherwise.
// tick is high during the last count of each period; limpa has priority.
module divisor_tick #(
  parameter int PRESC = 1000
) (
  input  logic clock,
  input  logic zera_as,
  input  logic habilita,
  input  logic limpa,
  output logic tick
);

  localparam int W = $clog2(PRESC);
  localparam logic [W-1:0] ULTIMO = W'(PRESC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = habilita && (cnt_q == ULTIMO);

  always_comb begin
    cnt_d = cnt_q;
    if (limpa) begin
      cnt_d = '0;
    end else if (habilita) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/temporizador_regressivo.sv
// Countdown game timer: loads a budget, decrements every PRESC cycles while running.
// Optional low-time warning output enabled with TEMPORIZADOR_AVISO_EN.
module temporizador_regressivo
  import temporizador_pkg::*;
#(
  parameter int M     = 99,
  parameter int N     = 7,
  parameter int PRESC = 1000,
  parameter int AVISO = 10
) (
  input  logic         clock,
  input  logic         zera_as,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic [N-1:0] valor,
  input  logic         inicia,
  input  logic         pausa,
  output logic [N-1:0] restante,
  output logic [1:0]   estado,
  output logic         esgotado,
  output logic         fim,
  output logic         aviso
);

  localparam logic [N-1:0] M_N = N'(M);
  localparam logic [N-1:0] UM  = N'(1);

  if (PRESC < 2 || (1 << N) <= M || AVISO < 0) begin : g_param_invalido
    $error("temporizador_regressivo: invalid parameter combination");
  end

  estado_t      estado_q, estado_d;
  logic [N-1:0] restante_q, restante_d;
  logic         esgotado_q, esgotado_d;
  logic         fim_q, fim_d;
  logic         tick;
  logic         limpa;
  logic         habilita;

  assign habilita = (estado_q == CONTANDO);

  divisor_tick #(.PRESC(PRESC)) u_divisor (
    .clock    (clock),
    .zera_as  (zera_as),
    .habilita (habilita),
    .limpa    (limpa),
    .tick     (tick)
  );

  always_comb begin
    estado_d   = estado_q;
    restante_d = restante_q;
    limpa      = 1'b0;
    if (zera_s) begin
      estado_d   = PARADO;
      restante_d = '0;
      limpa      = 1'b1;
    end else if (carrega) begin
      estado_d   = PARADO;
      restante_d = (valor > M_N) ? M_N : valor;
      limpa      = 1'b1;
    end else begin
      unique case (estado_q)
        CONTANDO: begin
          // Expiry on the tick outranks a simultaneous pause.
          if (tick) begin
            if (restante_q <= UM) begin
              restante_d = '0;
              estado_d   = ESGOTADO;
            end else begin
              restante_d = restante_q - UM;
              if (pausa) estado_d = PAUSADO;
            end
          end else if (pausa) begin
            estado_d = PAUSADO;
          end
        end
        PARADO, PAUSADO: begin
          if (!pausa && inicia) begin
            estado_d = (restante_q == '0) ? ESGOTADO : CONTANDO;
          end
        end
        default: ;
      endcase
      if (estado_d == ESGOTADO && estado_q != ESGOTADO) limpa = 1'b1;
    end
  end

  assign esgotado_d = (estado_d == ESGOTADO);
  assign fim_d      = (estado_d == ESGOTADO) && (estado_q != ESGOTADO);

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      estado_q   <= PARADO;
      restante_q <= '0;
      esgotado_q <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      restante_q <= restante_d;
      esgotado_q <= esgotado_d;
      fim_q      <= fim_d;
    end
  end

  assign restante = restante_q;
  assign estado   = estado_q;
  assign esgotado = esgotado_q;
  assign fim      = fim_q;

`ifdef TEMPORIZADOR_AVISO_EN
  logic aviso_q, aviso_d;

  always_comb begin
    aviso_d = ((estado_d == CONTANDO) || (estado_d == PAUSADO)) &&
              (restante_d != '0) && (int'(restante_d) <= AVISO);
  end

  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      aviso_q <= 1'b0;
    end else begin
      aviso_q <= aviso_d;
    end
  end

  assign aviso = aviso_q;
`else
  assign aviso = 1'b0;
`endif

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Self-checking bench for temporizador_regressivo (M=99, PRESC=4, AVISO=2).
// Reference model tracks the remaining budget in counting cycles rather than units.
module tb_temporizador_regressivo;

  localparam int M     = 99;
  localparam int N     = 7;
  localparam int PRESC = 4;
  localparam int AVISO = 2;

  logic         clock = 1'b0;
  logic         zera_as;
  logic         zera_s;
  logic         carrega;
  logic [N-1:0] valor;
  logic         inicia;
  logic         pausa;
  logic [N-1:0] restante;
  logic [1:0]   estado;
  logic         esgotado;
  logic         fim;
  logic         aviso;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  temporizador_regressivo #(.M(M), .N(N), .PRESC(PRESC), .AVISO(AVISO)) dut (
    .clock    (clock),
    .zera_as  (zera_as),
    .zera_s   (zera_s),
    .carrega  (carrega),
    .valor    (valor),
    .inicia   (inicia),
    .pausa    (pausa),
    .restante (restante),
    .estado   (estado),
    .esgotado (esgotado),
    .fim      (fim),
    .aviso    (aviso)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: budget left in counting cycles; displayed units are its ceiling over PRESC.
  int m_left  = 0;
  int m_state = 0;
  bit m_fim   = 1'b0;

  function automatic int m_rest();
    return (m_left + PRESC - 1) / PRESC;
  endfunction

  function automatic bit m_aviso();
`ifdef TEMPORIZADOR_AVISO_EN
    return (m_state == 1 || m_state == 2) && m_rest() >= 1 && m_rest() <= AVISO;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clock or posedge zera_as) begin
    int ns;
    if (zera_as) begin
      m_left  = 0;
      m_state = 0;
      m_fim   = 1'b0;
    end else begin
      ns = m_state;
      if (zera_s) begin
        m_left = 0;
        ns     = 0;
      end else if (carrega) begin
        m_left = ((int'(valor) > M) ? M : int'(valor)) * PRESC;
        ns     = 0;
      end else if (m_state == 1) begin
        m_left = m_left - 1;
        if (m_left == 0)  ns = 3;
        else if (pausa)   ns = 2;
      end else if ((m_state == 0 || m_state == 2) && !pausa && inicia) begin
        ns = (m_left == 0) ? 3 : 1;
      end
      m_fim   = (ns == 3) && (m_state != 3);
      m_state = ns;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_restante", restante, m_rest());
      check("cmp_estado",   estado,   m_state);
      check("cmp_esgotado", esgotado, m_state == 3);
      check("cmp_fim",      fim,      m_fim);
      check("cmp_aviso",    aviso,    m_aviso());
    end
  end

  task automatic pulse(input logic z, input logic c, input int v, input logic i, input logic p);
    zera_s  = z;
    carrega = c;
    valor   = N'(v);
    inicia  = i;
    pausa   = p;
    @(negedge clock);
    zera_s  = 1'b0;
    carrega = 1'b0;
    inicia  = 1'b0;
    pausa   = 1'b0;
  endtask

  initial begin
    zera_as = 1'b1;
    zera_s  = 1'b0;
    carrega = 1'b0;
    valor   = '0;
    inicia  = 1'b0;
    pausa   = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_restante", restante, 0);
    check("rst_estado",   estado,   0);
    check("rst_fim",      fim,      0);
    check("rst_esgotado", esgotado, 0);
    check("rst_aviso",    aviso,    0);
    zera_as = 1'b0;
    chk_en  = 1'b1;

    // Asynchronous reset while counting.
    pulse(0, 1, 5, 0, 0);
    pulse(0, 0, 0, 1, 0);
    repeat (6) @(negedge clock);
    check("t1_pre_restante", restante, 4);
    #2 zera_as = 1'b1;
    #1;
    check("t1_async_restante", restante, 0);
    check("t1_async_estado",   estado,   0);
    check("t1_async_fim",      fim,      0);
    @(negedge clock);
    zera_as = 1'b0;

    // Basic countdown of 3 units.
    pulse(0, 1, 3, 0, 0);
    pulse(0, 0, 0, 1, 0);
    check("t2_start", restante, 3);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      check("t2_restante", restante, (i < 12) ? 3 - i / 4 : 0);
      check("t2_fim",      fim,      i == 12);
      check("t2_esgotado", esgotado, i >= 12);
    end

    // Pause after two counting cycles, hold, resume.
    pulse(0, 1, 2, 0, 0);
    pulse(0, 0, 0, 1, 0);
    @(negedge clock);
    pulse(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      check("t3_frozen_restante", restante, 2);
      check("t3_frozen_estado",   estado,   2);
      @(negedge clock);
    end
    pulse(0, 0, 0, 1, 0);
    check("t3_resume_estado", estado, 1);
    @(negedge clock);
    check("t3_resume_r1", restante, 2);
    @(negedge clock);
    check("t3_resume_r2", restante, 1);

    // Saturation and zero load.
    pulse(0, 1, 120, 0, 0);
    check("t4_sat", restante, 99);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    check("t4_zero_estado", estado, 3);
    check("t4_zero_fim",    fim,    1);
    @(negedge clock);
    check("t4_zero_fim_once", fim,      0);
    check("t4_zero_esg",      esgotado, 1);

    // Load while expired, then clear+load together.
    pulse(0, 1, 7, 0, 0);
    check("t5_reload_estado",   estado,   0);
    check("t5_reload_restante", restante, 7);
    pulse(1, 1, 50, 0, 0);
    check("t5_clear_restante", restante, 0);
    check("t5_clear_estado",   estado,   0);

    // Pause coinciding with the final tick.
    pulse(0, 1, 1, 0, 0);
    pulse(0, 0, 0, 1, 0);
    repeat (3) @(negedge clock);
    pulse(0, 0, 0, 0, 1);
    check("t5_tickpause_estado", estado, 3);
    check("t5_tickpause_fim",    fim,    1);

    // Warning threshold.
    pulse(0, 1, 4, 0, 0);
    pulse(0, 0, 0, 1, 0);
    repeat (7) @(negedge clock);
    check("t6_r3_aviso", aviso, 0);
    @(negedge clock);
    check("t6_r2", restante, 2);
`ifdef TEMPORIZADOR_AVISO_EN
    check("t6_r2_aviso", aviso, 1);
`else
    check("t6_r2_aviso", aviso, 0);
`endif
    repeat (8) @(negedge clock);
    check("t6_r0",       restante, 0);
    check("t6_r0_aviso", aviso,    0);

    // Randomized command mix against the model.
    for (int c = 0; c < 3000; c++) begin
      zera_s  = ($urandom_range(0, 63) == 0);
      carrega = ($urandom_range(0, 15) == 0);
      valor   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 127))
                                            : N'($urandom_range(0, 5));
      pausa   = ($urandom_range(0, 7) == 0);
      inicia  = ($urandom_range(0, 5) == 0);
      @(negedge clock);
    end
    zera_s  = 1'b0;
    carrega = 1'b0;
    pausa   = 1'b0;
    inicia  = 1'b0;
    @(negedge clock);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/temporizador_regressivo.md
# temporizador_regressivo

Countdown game timer: loads a time budget, decrements it once every PRESC clock cycles while running, and reports expiry. It complements the up-counting play-time counter. The game FSM loads the per-question time limit, starts and pauses it, and reacts to the expiry pulse. The display path shows the remaining value.

## Interface
Parameters:
- M, 99: maximum loadable value; larger loads saturate to M
- N, 7: width of `valor`/`restante`; must satisfy 2^N > M
- PRESC, 1000: clock cycles per decrement (≥2)
- AVISO, 10: warning threshold (only used with the macro)

Ports:
- clock  in  1  system clock, rising edge
- zera_as  in  1  reset, asynchronous, active-high
- zera_s  in  1  synchronous clear
- carrega  in  1  load `valor` into the counter
- valor  in  N  budget to load
- inicia  in  1  start/resume
- pausa  in  1  pause
- restante  out  N  remaining units
- estado  out  2  current FSM state
- esgotado  out  1  level, high while in ESGOTADO
- fim  out  1  one-cycle expiry pulse
- aviso  out  1  low-time warning (macro-dependent)

## Operation
- States (2-bit): PARADO=0, CONTANDO=1, PAUSADO=2, ESGOTADO=3.
- Reset (`zera_as`) behaviour:
  - Outputs: estado=PARADO, restante=0, prescaler=0, fim=0, esgotado=0, aviso=0.
- Command priority each cycle: zera_s > carrega > pausa > inicia.
- zera_s: from any state, gives the same values as reset.
- carrega: from any state:
  - restante ← min(valor, M).
  - Prescaler ← 0; estado ← PARADO.
- inicia:
  - From PARADO or PAUSADO, with restante≠0: go to CONTANDO.
  - From PARADO or PAUSADO, with restante=0: go to ESGOTADO.
  - Ignored in CONTANDO and ESGOTADO.
- pausa: from CONTANDO, go to PAUSADO. Ignored elsewhere.
- Prescaler counting:
  - Counts 0..PRESC-1 only in CONTANDO.
  - Holds its value in PAUSADO, so a resume continues the partial period.
  - Cleared by carrega, zera_s and entry to ESGOTADO.
- Tick: prescaler=PRESC-1 in CONTANDO. On a tick:
  - The prescaler wraps to 0.
  - restante decrements.
  - If restante was 1, restante becomes 0 and estado goes to ESGOTADO.
- Tick and pausa in the same cycle: the decrement is applied and estado goes to PAUSADO. If that decrement reaches 0, ESGOTADO wins over PAUSADO.
- ESGOTADO is left only via carrega or zera_s. restante stays 0, with no wrap-around.
- esgotado = (estado==ESGOTADO).
- fim is high exactly in the first cycle estado==ESGOTADO. It is not re-asserted while ESGOTADO holds.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command latency: a command sampled at edge k is visible on `estado`/`restante` after edge k.
- Run latency from a fresh load:
  - inicia sampled at edge k.
  - First decrement after edge k+PRESC.
  - Later decrements every PRESC edges.
- Load value v with no pauses:
  - ESGOTADO and fim after edge k+v·PRESC.
- Pause/resume: total counting cycles are preserved exactly; paused cycles do not count.
- Reset: asynchronous assertion; release is synchronous to `clock` at system level.

## Configuration
- Macro: TEMPORIZADOR_AVISO_EN.
- Defined: aviso = (estado==CONTANDO or PAUSADO) and 0 < restante ≤ AVISO. It is registered and updates in the same cycle as `restante`.
- Undefined: aviso is tied to 0, and the AVISO comparator is not synthesized.

## Structure
- Shared package `temporizador_pkg`:
  - State encodings PARADO/CONTANDO/PAUSADO/ESGOTADO.
  - 2-bit state width constant.
- Sub-module `divisor_tick`:
  - Prescaler with parameter PRESC and a $clog2(PRESC)-bit counter.
  - Inputs: habilita, limpa. Output: one-cycle tick.
- Top level holds the FSM, restante register, saturation, fim/aviso logic.

## Test plan
1. Reset mid-count (M=99, PRESC=4): load 5, inicia, assert zera_as after 6 cycles -> restante=0, estado=PARADO, fim=0 immediately, without waiting for a clock edge.
2. Basic countdown (PRESC=4): load 3, inicia at edge k -> restante 2/1/0 after edges k+4/k+8/k+12. fim high only in the cycle after k+12; esgotado stays high.
3. Pause/resume: load 2, inicia, pausa after 2 counting cycles, hold 10 cycles, inicia -> first decrement 2 counting cycles after resume; restante frozen while paused.
4. Saturation and zero load: load 120 -> restante=99. Load 0, inicia -> ESGOTADO next edge with one fim pulse.
5. Simultaneous events:
   - zera_s+carrega together -> restante=0.
   - carrega in ESGOTADO -> PARADO with new value.
   - pausa on the tick cycle with restante=1 -> ESGOTADO, fim=1.
6. With TEMPORIZADOR_AVISO_EN, AVISO=2: load 4, run -> aviso rises with restante=2, falls at restante=0. Without the macro, aviso is always 0.
